// File: rtl/spi_slave.sv
// SPI peripheral endpoint: oversamples SPI_CLK/CS_n/MOSI in the clk domain, assembles MOSI
// bytes and shifts a user-supplied byte out on MISO, in any of the four SPI modes.
module spi_slave #(
  parameter int unsigned SPI_MODE = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic       o_MOSI_DV,
  output logic [7:0] o_MOSI_Byte,
  input  logic [7:0] i_MISO_Byte,
  input  logic       i_MISO_DV,
  output logic       o_MISO_Ready,
  input  logic       SPI_CLK,
  input  logic       CS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE
);

  localparam bit CPOL = (SPI_MODE & 32'd2) != 32'd0;
  localparam bit CPHA = (SPI_MODE & 32'd1) != 32'd0;

  typedef enum logic {StIdle, StActive} state_e;

  // [1] is the synchronized value, [2] the delayed copy used for edge detection
  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       miso_q, miso_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;

  logic       lead, trail, sample_edge, shift_edge, cs_fall, cs_rise, byte_start;
  logic [7:0] tx_src, rx_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q <= {3{CPOL}};
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_CLK};
      cs_q   <= {cs_q[1:0], CS_n};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  always_comb begin
    lead        = (sclk_q[1] != CPOL) && (sclk_q[2] == CPOL);
    trail       = (sclk_q[1] == CPOL) && (sclk_q[2] != CPOL);
    sample_edge = CPHA ? trail : lead;
    shift_edge  = CPHA ? lead : trail;
    cs_fall     = !cs_q[1] && cs_q[2];
    cs_rise     = cs_q[1] && !cs_q[2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    byte_d      = byte_q;
    dv_d        = 1'b0;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    byte_start  = 1'b0;
    rx_next     = {rx_q[6:0], mosi_q[1]};
    // A strobe coinciding with a byte-start load bypasses the holding register
    tx_src      = i_MISO_DV ? i_MISO_Byte : (hold_full_q ? hold_q : 8'h00);

    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (cs_fall) begin
          state_d    = StActive;
          byte_start = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
          miso_d  = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_d  = rx_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              byte_d     = rx_next;
              dv_d       = 1'b1;
              byte_start = 1'b1;
            end
          end
          // In CPHA=0 the shift edge after the 8th sample must not disturb the new bit 7
          if (shift_edge && (CPHA || cnt_q != 3'd0)) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (byte_start) begin
      if (CPHA) begin
        tx_d = tx_src;
      end else begin
        miso_d = tx_src[7];
        tx_d   = {tx_src[6:0], 1'b0};
      end
      hold_full_d = 1'b0;
    end else if (i_MISO_DV) begin
      hold_d      = i_MISO_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      byte_q      <= 8'h00;
      dv_q        <= 1'b0;
      miso_q      <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      byte_q      <= byte_d;
      dv_q        <= dv_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign o_MOSI_DV    = dv_q;
  assign o_MOSI_Byte  = byte_q;
  assign o_MISO_Ready = !hold_full_q;
  assign MISO         = miso_q;
  assign MISO_OE      = (state_q == StActive);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives a mode-0 and a mode-3 instance.
module tb_spi_slave;

  localparam int H = 4;  // clk cycles per SPI_CLK half period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] sclk = 2'b10;
  logic [1:0] cs_n = 2'b11;
  logic       mosi = 1'b0;
  logic [1:0] miso, oe, dv, ready;
  logic [1:0] miso_dv = 2'b00;
  logic [7:0] miso_byte [2];
  logic [7:0] mosi_byte [2];

  logic [7:0] rxq0 [$];
  logic [7:0] rxq1 [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_slave #(.SPI_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .o_MOSI_DV(dv[0]), .o_MOSI_Byte(mosi_byte[0]),
    .i_MISO_Byte(miso_byte[0]), .i_MISO_DV(miso_dv[0]), .o_MISO_Ready(ready[0]),
    .SPI_CLK(sclk[0]), .CS_n(cs_n[0]), .MOSI(mosi), .MISO(miso[0]), .MISO_OE(oe[0])
  );

  spi_slave #(.SPI_MODE(3)) dut3 (
    .clk(clk), .rst(rst), .o_MOSI_DV(dv[1]), .o_MOSI_Byte(mosi_byte[1]),
    .i_MISO_Byte(miso_byte[1]), .i_MISO_DV(miso_dv[1]), .o_MISO_Ready(ready[1]),
    .SPI_CLK(sclk[1]), .CS_n(cs_n[1]), .MOSI(mosi), .MISO(miso[1]), .MISO_OE(oe[1])
  );

  // Each high clk of o_MOSI_DV records one byte, so a stretched pulse shows up as extras
  always @(negedge clk) begin
    if (dv[0]) rxq0.push_back(mosi_byte[0]);
    if (dv[1]) rxq1.push_back(mosi_byte[1]);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [7:0] b);
    miso_byte[idx] = b;
    miso_dv[idx]   = 1'b1;
    wait_clk(1);
    miso_dv[idx]   = 1'b0;
  endtask

  task automatic cs_low(input int idx);
    cs_n[idx] = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high(input int idx);
    wait_clk(8);
    cs_n[idx] = 1'b1;
    wait_clk(8);
  endtask

  // idx 0 runs mode 0, idx 1 runs mode 3
  task automatic spi_xfer(input int idx, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    logic cpol;
    cpol = (idx == 1);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpol) begin
        mosi = tx[i];
        wait_clk(H);
        rx[i] = miso[idx];
        sclk[idx] = ~cpol;
        wait_clk(H);
        sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = tx[i];
        wait_clk(H);
        rx[i] = miso[idx];
        sclk[idx] = cpol;
        wait_clk(H);
      end
    end
  endtask

  task automatic test_reset();
    wait_clk(3);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({dv[i], mosi_byte[i], ready[i], miso[i], oe[i]} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_state[%0d]: got dv=%b byte=%h rdy=%b miso=%b oe=%b want 0/00/1/0/0",
                 i, dv[i], mosi_byte[i], ready[i], miso[i], oe[i]);
      end
    end
    rst = 1'b1;
    wait_clk(3);
  endtask

  task automatic test_mode3_loopback();
    logic [7:0] rx;
    int base;
    base = rxq1.size();
    load(1, 8'hA5);
    n_cmp++;
    if (ready[1] !== 1'b0) begin
      n_err++; $display("FAIL m3_ready_after_load: got %b want 0", ready[1]);
    end
    cs_low(1);
    n_cmp++;
    if (oe[1] !== 1'b1) begin
      n_err++; $display("FAIL m3_oe_active: got %b want 1", oe[1]);
    end
    spi_xfer(1, 8'h37, 8, rx);
    cs_high(1);
    n_cmp++;
    if (rx !== 8'hA5) begin
      n_err++; $display("FAIL m3_master_rx: got %h want a5", rx);
    end
    n_cmp++;
    if (rxq1.size() - base !== 1 || rxq1[base] !== 8'h37) begin
      n_err++; $display("FAIL m3_slave_rx: got %0d pulses byte %h want 1 pulse 37",
                        rxq1.size() - base, rxq1[base]);
    end
    n_cmp++;
    if ({ready[1], oe[1]} !== 2'b10) begin
      n_err++; $display("FAIL m3_end_state: got rdy=%b oe=%b want 1/0", ready[1], oe[1]);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] rx;
    int base;
    base = rxq0.size();
    load(0, 8'hA5);
    cs_low(0);
    n_cmp++;
    if ({miso[0], oe[0]} !== 2'b11) begin
      n_err++; $display("FAIL m0_first_bit: got miso=%b oe=%b want 1/1", miso[0], oe[0]);
    end
    spi_xfer(0, 8'h37, 8, rx);
    cs_high(0);
    n_cmp++;
    if (rx !== 8'hA5) begin
      n_err++; $display("FAIL m0_master_rx: got %h want a5", rx);
    end
    n_cmp++;
    if (rxq0.size() - base !== 1 || rxq0[base] !== 8'h37) begin
      n_err++; $display("FAIL m0_slave_rx: got %0d pulses byte %h want 1 pulse 37",
                        rxq0.size() - base, rxq0[base]);
    end
    n_cmp++;
    if (ready[0] !== 1'b1) begin
      n_err++; $display("FAIL m0_ready_end: got %b want 1", ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx_a, rx_b;
    int base;
    base = rxq1.size();
    load(1, 8'h11);
    cs_low(1);
    n_cmp++;
    if (ready[1] !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready_first: got %b want 1", ready[1]);
    end
    load(1, 8'h22);
    spi_xfer(1, 8'h38, 8, rx_a);
    spi_xfer(1, 8'h39, 8, rx_b);
    cs_high(1);
    n_cmp++;
    if ({rx_a, rx_b} !== 16'h1122) begin
      n_err++; $display("FAIL b2b_master_rx: got %h %h want 11 22", rx_a, rx_b);
    end
    n_cmp++;
    if (rxq1.size() - base !== 2 || rxq1[base] !== 8'h38 || rxq1[base+1] !== 8'h39) begin
      n_err++; $display("FAIL b2b_slave_rx: got %0d pulses %h %h want 2 pulses 38 39",
                        rxq1.size() - base, rxq1[base], rxq1[base+1]);
    end
  endtask

  task automatic test_no_tx();
    logic [7:0] rx;
    int base;
    base = rxq1.size();
    cs_low(1);
    spi_xfer(1, 8'h5A, 8, rx);
    cs_high(1);
    n_cmp++;
    if (rx !== 8'h00) begin
      n_err++; $display("FAIL notx_master_rx: got %h want 00", rx);
    end
    n_cmp++;
    if (rxq1.size() - base !== 1 || rxq1[base] !== 8'h5A) begin
      n_err++; $display("FAIL notx_slave_rx: got %0d pulses byte %h want 1 pulse 5a",
                        rxq1.size() - base, rxq1[base]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int base;
    base = rxq1.size();
    cs_low(1);
    spi_xfer(1, 8'hFF, 5, rx);
    cs_high(1);
    n_cmp++;
    if (rxq1.size() - base !== 0 || oe[1] !== 1'b0) begin
      n_err++; $display("FAIL abort_no_dv: got %0d pulses oe=%b want 0 pulses oe=0",
                        rxq1.size() - base, oe[1]);
    end
    cs_low(1);
    spi_xfer(1, 8'hC3, 8, rx);
    cs_high(1);
    n_cmp++;
    if (rxq1.size() - base !== 1 || rxq1[base] !== 8'hC3) begin
      n_err++; $display("FAIL abort_next_byte: got %0d pulses byte %h want 1 pulse c3",
                        rxq1.size() - base, rxq1[base]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    int base;
    load(1, 8'hFF);
    cs_low(1);
    load(1, 8'h77);
    spi_xfer(1, 8'h00, 4, rx);
    n_cmp++;
    if ({miso[1], ready[1], oe[1]} !== 3'b101) begin
      n_err++; $display("FAIL rstmid_pre: got miso=%b rdy=%b oe=%b want 1/0/1",
                        miso[1], ready[1], oe[1]);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({dv[1], mosi_byte[1], ready[1], miso[1], oe[1]} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_values: got dv=%b byte=%h rdy=%b miso=%b oe=%b want 0/00/1/0/0",
               dv[1], mosi_byte[1], ready[1], miso[1], oe[1]);
    end
    cs_n[1] = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(8);
    base = rxq1.size();
    cs_low(1);
    spi_xfer(1, 8'h81, 8, rx);
    cs_high(1);
    n_cmp++;
    if (rxq1.size() - base !== 1 || rxq1[base] !== 8'h81 || rx !== 8'h00) begin
      n_err++; $display("FAIL rstmid_fresh: got %0d pulses byte %h master %h want 1 pulse 81 / 00",
                        rxq1.size() - base, rxq1[base], rx);
    end
  endtask

  initial begin
    miso_byte[0] = 8'h00;
    miso_byte[1] = 8'h00;
    test_reset();
    test_mode3_loopback();
    test_mode0();
    test_back_to_back();
    test_no_tx();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
